fetch_unit: RTL and testbench

Instruction-fetch stage for riscv_basic. It sits directly upstream of the instruction memory and owns the program counter. It drives the PC to imem, which returns the instruction word combinationally in the same cycle, and captures that word into an IF/ID register. A valid/ready handshake delivers the captured word to decode. It also handles branch/jump redirects and flags misaligned or out-of-range fetch addresses.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_unit_if_id_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the riscv_basic fetch stage.
//   XLEN          - datapath width
//   NOP           - canonical addi x0,x0,0 used as the empty IF/ID instruction
//   fetch_state_t - fetch FSM states
//   fetch_err_t   - sticky fetch error codes
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FAULT
   } fetch_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10
   } fetch_err_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID valid/ready pipeline slot holding the fetched instruction and its PC.
//   clk, rst_n          - clock, asynchronous active-low reset
//   load                - capture instr_in/pc_in and mark the slot valid
//   flush               - empty the slot (wins over load and consume)
//   consume             - decode took the slot; empties it unless reloaded
//   instr_in, pc_in     - word and address being captured
//   valid, instr, pc,
//   pc_plus4            - slot contents presented to decode
module if_id_reg
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            flush,
   input  logic            consume,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

   // Data fields only change on load, so a stalled slot is held bit-for-bit.
   always_comb begin
      valid_d    = flush ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : valid_q;
      instr_d    = load ? instr_in : instr_q;
      pc_d       = load ? pc_in : pc_q;
      pc_plus4_d = load ? pc_in + XLEN'(4) : pc_plus4_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP;
         pc_q       <= '0;
         pc_plus4_q <= XLEN'(4);
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc       = pc_q;
   assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, fetch FSM, redirects and fetch faults.
//   clk, rst_n                      - clock, asynchronous active-low reset
//   fetch_en                        - run request; low parks the stage
//   imem_pc / imem_instr            - fetch address out, combinational instruction back
//   redirect_valid/redirect_target  - taken branch/jump from execute
//   id_valid/id_ready               - handshake with decode
//   id_instr, id_pc, id_pc_plus4    - captured instruction and its addresses
//   fetch_err                       - sticky error: 00 none, 01 misaligned, 10 out of range
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_en,
   output logic [XLEN-1:0] imem_pc,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [1:0]      fetch_err
);

   localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

   fetch_state_t    state_q, state_d;
   fetch_err_t      err_q, err_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fire, load, flush, consume;

   assign fire    = fetch_en & (~id_valid | id_ready) & ~redirect_valid;
   assign consume = id_valid & id_ready;

   // Redirect outranks everything; a would-be fire past the end of imem
   // faults instead of capturing. FAULT freezes pc and err until reset.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      if (state_q != FAULT) begin
         state_d = fetch_en ? RUN : IDLE;
         if (redirect_valid) begin
            pc_d  = redirect_target;
            flush = 1'b1;
            if (|redirect_target[1:0]) begin
               err_d   = ERR_MISALIGN;
               state_d = FAULT;
            end
         end else if (state_q == RUN && fire) begin
            if (pc_q >= PC_LIMIT) begin
               err_d   = ERR_RANGE;
               state_d = FAULT;
               flush   = 1'b1;
            end else begin
               load = 1'b1;
               pc_d = pc_q + XLEN'(4);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= ERR_NONE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         pc_q    <= pc_d;
      end
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .flush    (flush),
      .consume  (consume),
      .instr_in (imem_instr),
      .pc_in    (pc_q),
      .valid    (id_valid),
      .instr    (id_instr),
      .pc       (id_pc),
      .pc_plus4 (id_pc_plus4)
   );

   assign imem_pc   = pc_q;
   assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a behavioural model.
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic        id_ready = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_pc, imem_instr, id_instr, id_pc, id_pc_plus4;
   logic        id_valid;
   logic [1:0]  fetch_err;
   logic [31:0] mem [64];

   int checks = 0;
   int failures = 0;

   bit          m_run, m_fault, m_valid;
   logic [31:0] m_pc, m_ipc;
   logic [1:0]  m_err;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_pc[7:2]];

   fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_en        (fetch_en),
      .imem_pc         (imem_pc),
      .imem_instr      (imem_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .fetch_err       (fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Spec-level model: one edge of the fetch stage given the current inputs.
   task automatic model_step;
      bit fire;
      if (m_fault) return;
      fire = fetch_en && (!m_valid || id_ready) && !redirect_valid;
      if (redirect_valid) begin
         m_pc    = redirect_target;
         m_valid = 0;
         if (redirect_target % 4 != 0) begin
            m_fault = 1;
            m_err   = 2'b01;
         end
      end else if (m_run && fire) begin
         if (m_pc >= 32'd256) begin
            m_fault = 1;
            m_err   = 2'b10;
            m_valid = 0;
         end else begin
            m_valid = 1;
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
         end
      end else if (m_valid && id_ready) begin
         m_valid = 0;
      end
      m_run = fetch_en && !m_fault;
   endtask

   task automatic check_all;
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("imem_pc", imem_pc, m_pc);
      chk("fetch_err", {30'b0, fetch_err}, {30'b0, m_err});
      if (m_valid) begin
         chk("id_pc", id_pc, m_ipc);
         chk("id_pc_plus4", id_pc_plus4, m_ipc + 32'd4);
         chk("id_instr", id_instr, mem[m_ipc[7:2]]);
      end
   endtask

   task automatic tick;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      #1;
      m_run = 0; m_fault = 0; m_valid = 0; m_pc = 32'h0; m_ipc = 32'h0; m_err = 2'b00;
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_instr", id_instr, NOP);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_pc_plus4", id_pc_plus4, 32'h4);
      chk("rst_err", {30'b0, fetch_err}, 32'h0);
      chk("rst_imem_pc", imem_pc, 32'h0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] last_pc;
      int          r;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      @(posedge clk);
      #1;
      do_reset();

      // enable latency and sequential stream
      fetch_en = 1; id_ready = 1;
      tick();
      chk("t1_latency", {31'b0, id_valid}, 32'h0);
      tick();
      chk("t1_first_valid", {31'b0, id_valid}, 32'h1);
      chk("t1_first_pc", id_pc, 32'h0);
      chk("t1_first_instr", id_instr, mem[0]);
      tick();
      tick();
      chk("t1_pc8", id_pc, 32'h8);

      // stall holds everything, release continues without skip
      id_ready = 0;
      repeat (3) tick();
      chk("t2_hold_pc", id_pc, 32'h8);
      chk("t2_hold_instr", id_instr, mem[2]);
      chk("t2_hold_imem_pc", imem_pc, 32'hC);
      id_ready = 1;
      tick();
      chk("t2_next_pc", id_pc, 32'hC);

      // redirect flushes an unconsumed slot
      tick();
      chk("t3_slot10", id_pc, 32'h10);
      id_ready = 0;
      tick();
      redirect_valid = 1; redirect_target = 32'h40;
      tick();
      redirect_valid = 0;
      chk("t3_flushed", {31'b0, id_valid}, 32'h0);
      chk("t3_pc40", imem_pc, 32'h40);
      id_ready = 1;
      tick();
      chk("t3_capture40", id_pc, 32'h40);

      // park with a held slot, drain, resume after one idle cycle
      id_ready = 0; fetch_en = 0;
      tick();
      tick();
      chk("t6_held", id_pc, 32'h40);
      chk("t6_no_fetch", imem_pc, 32'h44);
      id_ready = 1;
      tick();
      chk("t6_drained", {31'b0, id_valid}, 32'h0);
      fetch_en = 1;
      tick();
      chk("t6_idle_cycle", {31'b0, id_valid}, 32'h0);
      tick();
      chk("t6_resume", id_pc, 32'h44);

      // run off the end of imem
      redirect_valid = 1; redirect_target = 32'hF0;
      tick();
      redirect_valid = 0;
      last_pc = 32'hFFFF_FFFF;
      for (int i = 0; i < 40 && fetch_err == 2'b00; i++) begin
         tick();
         if (id_valid) last_pc = id_pc;
      end
      chk("t5_last_pc", last_pc, 32'hFC);
      chk("t5_err", {30'b0, fetch_err}, 32'h2);
      repeat (3) tick();
      chk("t5_no_capture", {31'b0, id_valid}, 32'h0);
      chk("t5_pc_frozen", imem_pc, 32'h100);

      // misaligned redirect is terminal until reset
      do_reset();
      tick();
      redirect_valid = 1; redirect_target = 32'h22;
      tick();
      chk("t4_err", {30'b0, fetch_err}, 32'h1);
      chk("t4_valid", {31'b0, id_valid}, 32'h0);
      redirect_target = 32'h0;
      tick();
      redirect_valid = 0;
      repeat (2) tick();
      chk("t4_ignored", imem_pc, 32'h22);
      chk("t4_err_sticky", {30'b0, fetch_err}, 32'h1);
      do_reset();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         fetch_en = ($urandom % 8) != 0;
         id_ready = ($urandom % 3) != 0;
         redirect_valid = ($urandom % 16) == 0;
         r = $urandom % 32;
         if (r == 0) redirect_target = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
         else if (r == 1) redirect_target = 32'h100 + {$urandom_range(0, 15), 2'b00};
         else redirect_target = {$urandom_range(0, 63), 2'b00};
         if ((m_fault && ($urandom % 8) == 0) || ($urandom % 500) == 0) do_reset();
         else tick();
      end
      redirect_valid = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
